// File: rtl/uart_tx_arbiter_if.sv
// Byte-channel bundle between NUM_REQ requesters, the round-robin arbiter and
// the uart_transmitter input port. Requester byte i lives on req_data[8i+7:8i].
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;

  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant, busy
  );

  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit byte channel; a grant is held for a
// whole message, bounded by MAX_BURST bytes and an IDLE_TIMEOUT stall reclaim.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BURST_W = $clog2(MAX_BURST) + 1;
  localparam int IDLE_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT  = BURST_W'(MAX_BURST - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LIMIT   = IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   w_grant_next;
  logic [IDX_W-1:0]     r_gidx;
  logic [IDX_W-1:0]     w_gidx_next;
  logic [IDX_W-1:0]     r_last_idx;
  logic [IDX_W-1:0]     w_last_idx_next;
  logic [BURST_W-1:0]   r_burst_cnt;
  logic [BURST_W-1:0]   w_burst_cnt_next;
  logic [IDLE_W-1:0]    r_idle_cnt;
  logic [IDLE_W-1:0]    w_idle_cnt_next;

  logic [7:0]           w_req_byte [NUM_REQ];
  logic                 w_locked;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic [7:0]           w_sel_data;
  logic                 w_fire;
  logic                 w_release;
  logic                 w_arb_found;
  logic [IDX_W-1:0]     w_arb_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_byte[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // r_gidx mirrors the one-hot grant so the owner mux needs no encoder.
  assign w_locked    = (r_state == ST_LOCKED);
  assign w_sel_valid = bus.req_valid[r_gidx];
  assign w_sel_last  = bus.req_last[r_gidx];
  assign w_sel_data  = w_req_byte[r_gidx];
  assign w_fire      = w_locked & w_sel_valid & bus.tx_ready;
  assign w_release   = (w_fire & (w_sel_last | (r_burst_cnt == BURST_LIMIT)))
                     | (w_locked & ~w_sel_valid & (r_idle_cnt == IDLE_LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_gidx      <= '0;
      r_last_idx  <= LAST_IDX_RST;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_gidx      <= w_gidx_next;
      r_last_idx  <= w_last_idx_next;
      r_burst_cnt <= w_burst_cnt_next;
      r_idle_cnt  <= w_idle_cnt_next;
    end
  end

  always_comb begin
    int cand;
    w_state_next     = r_state;
    w_grant_next     = r_grant;
    w_gidx_next      = r_gidx;
    w_last_idx_next  = r_last_idx;
    w_burst_cnt_next = r_burst_cnt;
    w_idle_cnt_next  = r_idle_cnt;
    w_arb_found      = 1'b0;
    w_arb_idx        = '0;
    cand             = 0;

    // Scan last_idx+1, last_idx+2, ... so the previous owner is considered last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(r_last_idx) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!w_arb_found && bus.req_valid[cand[IDX_W-1:0]]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = cand[IDX_W-1:0];
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (w_arb_found) begin
          w_state_next            = ST_LOCKED;
          w_grant_next            = '0;
          w_grant_next[w_arb_idx] = 1'b1;
          w_gidx_next             = w_arb_idx;
          w_burst_cnt_next        = '0;
          w_idle_cnt_next         = '0;
        end
      end
      ST_LOCKED: begin
        if (w_release) begin
          w_state_next     = ST_IDLE;
          w_grant_next     = '0;
          w_last_idx_next  = r_gidx;
          w_burst_cnt_next = '0;
          w_idle_cnt_next  = '0;
        end else begin
          if (w_fire) begin
            w_burst_cnt_next = r_burst_cnt + BURST_W'(1);
          end
          if (w_sel_valid) begin
            w_idle_cnt_next = '0;
          end else begin
            w_idle_cnt_next = r_idle_cnt + IDLE_W'(1);
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  always_comb begin
    bus.grant     = r_grant;
    bus.busy      = w_locked;
    bus.tx_valid  = w_locked & w_sel_valid;
    bus.tx_data   = w_locked ? w_sel_data : 8'h00;
    bus.req_ready = w_locked ? (r_grant & {NUM_REQ{bus.tx_ready}}) : '0;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `uart_transmitter` byte channel among `NUM_REQ` requesters, e.g. the CPU MMIO path, a hardware debug printer and a BIST reporter. A granted requester keeps the channel for a whole message, up to `MAX_BURST` bytes, so messages are not interleaved on the serial line. An idle-timeout reclaims the channel from a requester that stalls mid-message. The block sits directly in front of `uart_transmitter`: `tx_*` connects to its `data_in*`.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `MAX_BURST`, 16: maximum bytes per grant; legal range 1..255.
- `IDLE_TIMEOUT`, 4096: consecutive granted cycles with `req_valid[g]`=0 before forced release; legal range 1..65535.

- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `req_data`  in  8*NUM_REQ  byte from requester i on bits [8i+7:8i].
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_last`  in  NUM_REQ  marks the byte as the final byte of the message; sampled only with valid.
- `req_ready`  out  NUM_REQ  per-requester accept.
- `tx_data`  out  8  byte to transmitter.
- `tx_valid`  out  1  to transmitter `data_in_valid`.
- `tx_ready`  in  1  from transmitter `data_in_ready`.
- `grant`  out  NUM_REQ  one-hot current owner; all-zero when idle.
- `busy`  out  1  high while in LOCKED.

## Operation
- State machine has two states, IDLE and LOCKED.
- Registers:
  - `state`
  - `grant` (one-hot)
  - `last_idx`, the index of the last granted requester, clog2(NUM_REQ) bits
  - `burst_cnt`, clog2(MAX_BURST)+1 bits
  - `idle_cnt`, clog2(IDLE_TIMEOUT+1) bits
- Reset values: state=IDLE, grant=0, last_idx=NUM_REQ-1 (so requester 0 has first priority), counters=0. All outputs are therefore 0 during and after reset until a grant.
- **IDLE:**
  - If any `req_valid` is high, select the first valid index scanning `last_idx+1`, `last_idx+2`, … modulo NUM_REQ.
  - Next cycle: `grant` = one-hot of the selected index, state=LOCKED, counters cleared.
  - If no `req_valid` is high, remain in IDLE.
- **LOCKED** (g = granted index):
  - `tx_valid` = `req_valid[g]`.
  - `tx_data` = `req_data[g]`.
  - `req_ready[g]` = `tx_ready`; all other `req_ready` = 0.
  - These paths are combinational, pass-through in the same cycle.
- A byte transfer ("fire") occurs when `tx_valid && tx_ready`.
  - On fire: `burst_cnt`++ and `idle_cnt` is cleared.
- Release to IDLE on the next edge, setting last_idx=g and grant=0, when any of the following holds:
  - fire with `req_last[g]`=1;
  - fire with `burst_cnt`==MAX_BURST-1, i.e. this is the MAX_BURST-th byte;
  - `idle_cnt`==IDLE_TIMEOUT-1 while `req_valid[g]`=0, i.e. the IDLE_TIMEOUT-th consecutive idle cycle.
- `idle_cnt` increments on LOCKED cycles with `req_valid[g]`=0, and clears when `req_valid[g]`=1.
- Bytes are never dropped or duplicated. A requester released by burst limit or timeout simply re-arbitrates and competes round-robin.
- Requesters must hold `req_data`/`req_last` stable while valid and not ready. The arbiter does not buffer.
- Asserting `reset` mid-message forces IDLE immediately, with grant=0 and `tx_valid`=0. The transmitter finishes any byte already accepted; the requester re-sends the rest after reset.

## Timing
- Arbitration latency: `req_valid` first high in cycle t (IDLE) gives `grant`/`busy` high in t+1, and `tx_valid` high in t+1.
- A fire in t+1 is possible if `tx_ready`=1.
- Release: fire with last in cycle t gives IDLE at t+1, and the next grant at t+2. There is exactly one bubble cycle between owners, which is negligible against the ≥1 symbol-time per byte of the transmitter.
- Throughput within a grant is limited only by `tx_ready`.
- Simultaneous last and burst-limit on the same fire cause a single release; there is no double count.
- Timeout and a new `req_valid[g]` in the same cycle: valid wins and `idle_cnt` clears. Release occurs only if valid=0 in that cycle.

## Test plan
- **Reset/idle:** hold reset 5 cycles with all `req_valid`=1 → `grant`=0, `tx_valid`=0, all `req_ready`=0. After deassert, `grant`=4'b0001 one cycle later.
- **Message lock:** req1 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) while req2 is valid throughout → `tx_data` shows 0x41,0x42,0x43 contiguously, `req_ready[2]` stays 0, `grant` becomes 4'b0100 one idle cycle after release.
- **Round-robin:** all four requesters continuously send 1-byte messages → grant order 0,1,2,3,0,…; no index repeats before the others are served.
- **Burst limit:** MAX_BURST=4, req0 sends 10 bytes with no last while req3 is valid → req0 is released after its 4th byte, req3 is granted, req0 resumes later with byte 5. All 10 bytes are delivered in order.
- **Timeout:** IDLE_TIMEOUT=8, req2 sends 1 byte without last then drops valid → release after 8 idle cycles, `busy`=0. If valid returns at idle cycle 7, no release.
- **Back-pressure and reset:** `tx_ready` held low 1000 cycles with req0 valid → `req_ready[0]`=0 and data stays stable. Assert reset mid-message → `tx_valid` drops asynchronously and `grant`=0.
